reg_native_arb: RTL and testbench
=================================

Name: reg_native_arb

Overview:
- Arbitrates MST_NUM upstream reg_native_if masters (regmst instances, debug port, etc.) onto one downstream reg_native_if toward a regslv.
- Round-robin, one outstanding transaction at a time.
- Grant is held from request handshake through ack handshake, so the downstream regslv sees a single well-formed master.

Parameters:
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 32, data width.
- MST_NUM, 2, number of upstream masters (2..8).
- TIMEOUT_CYCLES, 255, ack timeout limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- s_req_vld  in  MST_NUM  per-master request valid.
- s_req_rdy  out  MST_NUM  per-master request ready.
- s_wr_en  in  MST_NUM  per-master write enable.
- s_rd_en  in  MST_NUM  per-master read enable.
- s_addr  in  MST_NUM*ADDR_WIDTH  per-master address, packed, master 0 in LSBs.
- s_wr_data  in  MST_NUM*DATA_WIDTH  per-master write data, packed.
- s_ack_vld  out  MST_NUM  per-master ack valid.
- s_ack_rdy  in  MST_NUM  per-master ack ready.
- s_rd_data  out  DATA_WIDTH  read data, broadcast to all masters; qualified by s_ack_vld.
- req_vld  out  1  downstream request valid.
- req_rdy  in  1  downstream request ready.
- wr_en  out  1  downstream write enable.
- rd_en  out  1  downstream read enable.
- addr  out  ADDR_WIDTH  downstream address.
- wr_data  out  DATA_WIDTH  downstream write data.
- ack_vld  in  1  downstream ack valid.
- ack_rdy  out  1  downstream ack ready.
- rd_data  in  DATA_WIDTH  downstream read data.
- grant_idx  out  $clog2(MST_NUM)  index of the current/last granted master.
- busy  out  1  high in REQ or ACK.

Behaviour:
- Reset (srst high at a clk edge): state=IDLE, rr_ptr=MST_NUM-1, grant_idx=0. s_req_rdy, s_ack_vld, req_vld, ack_rdy and busy are all 0 from the next cycle. Reset mid-transaction abandons the transaction; nothing is replayed.
- FSM states: IDLE, REQ, ACK.
- IDLE:
  - If any s_req_vld, select the first requester searching from rr_ptr+1 upward, modulo MST_NUM.
  - Register the choice into grant_idx and go to REQ.
  - Arbitration latency is one cycle: downstream req_vld rises the cycle after s_req_vld.
- REQ:
  - req_vld = s_req_vld[grant_idx]. wr_en, rd_en, addr and wr_data are muxed combinationally from the granted master.
  - s_req_rdy[grant_idx] = req_rdy; all other s_req_rdy are 0.
  - On req_vld & req_rdy, go to ACK.
  - If the granted master drops s_req_vld (protocol violation), stay in REQ with req_vld low.
- ACK:
  - ack_rdy = s_ack_rdy[grant_idx]; s_ack_vld[grant_idx] = ack_vld; s_rd_data = rd_data.
  - On ack_vld & ack_rdy: rr_ptr <= grant_idx, go to IDLE. The next grant is earliest two cycles later.
- Outside ACK, ack_rdy=0 and all s_ack_vld=0. A downstream ack arriving during REQ is held by the slave until ACK.
- Non-granted masters always see s_req_rdy=0 and s_ack_vld=0. Their requests stay pending and are never dropped.
- wr_en and rd_en are forwarded unmodified; a master asserting both is a master error and is not corrected.
- Fairness: with all MST_NUM masters continuously requesting, each is granted once every MST_NUM transactions.

Optional Feature:
- Macro REG_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit cycle counter clears on entry to ACK and increments each cycle in ACK.
  - When the count reaches TIMEOUT_CYCLES without an ack handshake, the arbiter drives s_ack_vld[grant_idx]=1 with s_rd_data=32'hDEAD_BEEF (TIMEOUT_RDATA) and holds it until s_ack_rdy.
  - ack_rdy is held 0 during the synthetic ack; the arbiter then returns to IDLE.
  - Output port timeout_err pulses high for one cycle when the timeout fires.
  - A late downstream ack is left pending at the slave.
- Undefined: no counter, no timeout_err port; ACK waits indefinitely.

Decomposition:
- Package reg_arb_pkg:
  - arb_state_e enum {IDLE, REQ, ACK}.
  - TIMEOUT_RDATA constant.
  - Default TIMEOUT_CYCLES.
- Sub-module reg_arb_rr_pick: combinational round-robin selector.
  - Inputs: request vector, rr_ptr.
  - Outputs: winner index, any_req.

Test Plan:
- Master 0 writes addr 0x10 data 0x12345678, MST_NUM=2 -> req_vld rises 1 cycle after s_req_vld[0] with wr_en=1, addr=0x10, wr_data=0x12345678. Ack is routed to s_ack_vld[0] only; grant_idx=0.
- Both masters request every cycle after reset -> grant order 0,1,0,1. Master 1 reads return rd_data 0x12345678 on s_rd_data with only s_ack_vld[1] high.
- Downstream holds req_rdy=0 for 5 cycles -> FSM stays in REQ, addr/wr_data stable, s_req_rdy[0]=0 throughout, and master 1's pending request is not granted.
- Master 0 holds s_ack_rdy=0 for 3 cycles while ack_vld=1 -> ack_rdy=0 for those cycles, FSM stays in ACK, busy=1. The handshake completes on cycle 4.
- srst asserted for 1 cycle while in ACK -> next cycle all outputs 0 and state IDLE. Simultaneous requests then grant master 0 first.
- With REG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, downstream never acks -> after 16 cycles in ACK, s_ack_vld[0]=1 with s_rd_data=0xDEADBEEF and a 1-cycle timeout_err pulse. Then IDLE.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// ============================================================================
//  Module      : reg_arb_pkg
//  Description : Shared types and constants for the reg_native_if arbiter.
//                Holds the arbiter FSM state encoding, the read data returned
//                on a synthetic (timed-out) ack, and the default ack timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

    // Read data returned to the granted master when the slave never acks
    localparam logic [31:0] TIMEOUT_RDATA          = 32'hDEAD_BEEF;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int          TIMEOUT_CNT_W          = 16;

endpackage : reg_arb_pkg

`default_nettype wire

// File: rtl/reg_arb_rr_pick.sv
// ============================================================================
//  Module      : reg_arb_rr_pick
//  Description : Combinational round-robin selector. Returns the first
//                asserted request found searching upward from i_ptr+1,
//                wrapping modulo N, plus an any-request flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_arb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_j;

    // Scan from the farthest candidate back to ptr+1 so the nearest requester wins
    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        w_j   = '0;
        for (int k = N; k >= 1; k--) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) begin
                o_idx = w_j;
            end
        end
    end

endmodule : reg_arb_rr_pick

`default_nettype wire

// File: rtl/reg_native_arb.sv
// ============================================================================
//  Module      : reg_native_arb
//  Description : Round-robin arbiter of MST_NUM reg_native_if masters onto a
//                single downstream reg_native_if. One transaction in flight;
//                the grant is held from request handshake to ack handshake.
//                Optional ack timeout enabled by macro REG_ARB_TIMEOUT_EN
//                (adds the timeout_err output port).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_native_arb
    import reg_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int MST_NUM        = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [MST_NUM-1:0]            s_req_vld,
    output logic [MST_NUM-1:0]            s_req_rdy,
    input  logic [MST_NUM-1:0]            s_wr_en,
    input  logic [MST_NUM-1:0]            s_rd_en,
    input  logic [MST_NUM*ADDR_WIDTH-1:0] s_addr,
    input  logic [MST_NUM*DATA_WIDTH-1:0] s_wr_data,
    output logic [MST_NUM-1:0]            s_ack_vld,
    input  logic [MST_NUM-1:0]            s_ack_rdy,
    output logic [DATA_WIDTH-1:0]         s_rd_data,
    output logic                          req_vld,
    input  logic                          req_rdy,
    output logic                          wr_en,
    output logic                          rd_en,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          ack_vld,
    output logic                          ack_rdy,
    input  logic [DATA_WIDTH-1:0]         rd_data,
`ifdef REG_ARB_TIMEOUT_EN
    output logic                          timeout_err,
`endif
    output logic [$clog2(MST_NUM)-1:0]    grant_idx,
    output logic                          busy
);

    localparam int IW = $clog2(MST_NUM);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [IW-1:0]           r_grant;
    logic [IW-1:0]           r_rr_ptr;
    logic [IW-1:0]           w_pick;
    logic                    w_any;
    logic                    w_done;
    logic                    w_syn;
    logic [ADDR_WIDTH-1:0]   w_addr_arr  [MST_NUM];
    logic [DATA_WIDTH-1:0]   w_wdata_arr [MST_NUM];

    // Unpack the per-master address and write-data buses for indexed muxing
    for (genvar i = 0; i < MST_NUM; i++) begin : g_unpack
        assign w_addr_arr[i]  = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[i] = s_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    reg_arb_rr_pick #(
        .N  (MST_NUM),
        .IW (IW)
    ) u_rr_pick (
        .i_req (s_req_vld),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

`ifdef REG_ARB_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] r_to_cnt;
    logic                     r_to_hold;
    logic                     w_to_fire;

    // Fires on the cycle the count reaches the limit; the synthetic ack is
    // then held (r_to_hold) until the granted master accepts it.
    assign w_to_fire   = (r_state == ACK) && !r_to_hold &&
                         (r_to_cnt == TIMEOUT_CNT_W'(TIMEOUT_CYCLES));
    assign w_syn       = w_to_fire | r_to_hold;
    assign timeout_err = w_to_fire;

    // Ack wait counter: zero outside ACK, counts while waiting for the slave
    always_ff @(posedge clk) begin
        if (srst || (r_state != ACK)) begin
            r_to_cnt  <= '0;
            r_to_hold <= 1'b0;
        end else if (w_to_fire && !s_ack_rdy[r_grant]) begin
            r_to_hold <= 1'b1;
        end else if (!w_syn) begin
            r_to_cnt  <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_syn = 1'b0;
`endif

    assign grant_idx = r_grant;
    assign busy      = (r_state != IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant capture in IDLE; round-robin pointer advances on transaction end
    always_ff @(posedge clk) begin
        if (srst) begin
            r_grant  <= '0;
            r_rr_ptr <= IW'(MST_NUM - 1);
        end else begin
            if ((r_state == IDLE) && w_any) begin
                r_grant <= w_pick;
            end
            if (w_done) begin
                r_rr_ptr <= r_grant;
            end
        end
    end

    // Next-state and routing: only the granted master ever sees rdy/ack
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        s_req_rdy   = '0;
        s_ack_vld   = '0;
        s_rd_data   = '0;
        req_vld     = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        addr        = '0;
        wr_data     = '0;
        ack_rdy     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                req_vld            = s_req_vld[r_grant];
                wr_en              = s_wr_en[r_grant];
                rd_en              = s_rd_en[r_grant];
                addr               = w_addr_arr[r_grant];
                wr_data            = w_wdata_arr[r_grant];
                s_req_rdy[r_grant] = req_rdy;
                if (s_req_vld[r_grant] && req_rdy) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                if (w_syn) begin
                    // Slave never answered: ack_rdy stays low so its late ack stays pending
                    s_ack_vld[r_grant] = 1'b1;
                    s_rd_data          = DATA_WIDTH'(TIMEOUT_RDATA);
                    if (s_ack_rdy[r_grant]) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    ack_rdy            = s_ack_rdy[r_grant];
                    s_ack_vld[r_grant] = ack_vld;
                    s_rd_data          = rd_data;
                    if (ack_vld && s_ack_rdy[r_grant]) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule : reg_native_arb

`default_nettype wire

// File: tb/tb_reg_native_arb.sv
// ============================================================================
//  Module      : tb_reg_native_arb
//  Description : Self-checking bench for reg_native_arb (MST_NUM=2). A table
//                of single transactions checks routing and round-robin order;
//                hand-written sequences cover stalls, reset mid-transaction
//                and (with REG_ARB_TIMEOUT_EN) the ack timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_native_arb;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int N  = 2;

    logic            clk = 1'b0;
    logic            srst;
    logic [N-1:0]    s_req_vld;
    logic [N-1:0]    s_req_rdy;
    logic [N-1:0]    s_wr_en;
    logic [N-1:0]    s_rd_en;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wr_data;
    logic [N-1:0]    s_ack_vld;
    logic [N-1:0]    s_ack_rdy;
    logic [DW-1:0]   s_rd_data;
    logic            req_vld;
    logic            req_rdy;
    logic            wr_en;
    logic            rd_en;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wr_data;
    logic            ack_vld;
    logic            ack_rdy;
    logic [DW-1:0]   rd_data;
    logic [0:0]      grant_idx;
    logic            busy;
`ifdef REG_ARB_TIMEOUT_EN
    logic            timeout_err;
`endif

    always #5 clk = ~clk;

    reg_native_arb #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MST_NUM        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .s_req_vld   (s_req_vld),
        .s_req_rdy   (s_req_rdy),
        .s_wr_en     (s_wr_en),
        .s_rd_en     (s_rd_en),
        .s_addr      (s_addr),
        .s_wr_data   (s_wr_data),
        .s_ack_vld   (s_ack_vld),
        .s_ack_rdy   (s_ack_rdy),
        .s_rd_data   (s_rd_data),
        .req_vld     (req_vld),
        .req_rdy     (req_rdy),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .addr        (addr),
        .wr_data     (wr_data),
        .ack_vld     (ack_vld),
        .ack_rdy     (ack_rdy),
        .rd_data     (rd_data),
`ifdef REG_ARB_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .grant_idx   (grant_idx),
        .busy        (busy)
    );

    typedef struct {
        logic [1:0]  req;
        logic        wr;
        logic [63:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        int          exp_g;
    } vec_t;

    vec_t vecs [7];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mst(input int m, input logic wr, input logic [63:0] a, input logic [31:0] d);
        s_wr_en[m]             = wr;
        s_rd_en[m]             = !wr;
        s_addr[m*AW +: AW]     = a;
        s_wr_data[m*DW +: DW]  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g;
        int fire_at;
        logic [63:0] ea;

        // Master m uses address vec.addr + m*0x100 and data vec.data + m
        vecs[0] = '{req: 2'b01, wr: 1'b1, addr: 64'h10,   data: 32'h1234_5678, rdata: 32'h0000_0000, exp_g: 0};
        vecs[1] = '{req: 2'b11, wr: 1'b0, addr: 64'h20,   data: 32'h0000_0000, rdata: 32'h1234_5678, exp_g: 1};
        vecs[2] = '{req: 2'b11, wr: 1'b1, addr: 64'h30,   data: 32'hA5A5_0000, rdata: 32'h0000_0001, exp_g: 0};
        vecs[3] = '{req: 2'b11, wr: 1'b0, addr: 64'h40,   data: 32'h0000_0100, rdata: 32'h8765_4321, exp_g: 1};
        vecs[4] = '{req: 2'b10, wr: 1'b1, addr: 64'h50,   data: 32'h5A5A_5A5A, rdata: 32'hFFFF_FFFF, exp_g: 1};
        vecs[5] = '{req: 2'b01, wr: 1'b0, addr: 64'h1000, data: 32'h0000_0200, rdata: 32'h0BAD_F00D, exp_g: 0};
        vecs[6] = '{req: 2'b11, wr: 1'b1, addr: 64'h60,   data: 32'hC0DE_0000, rdata: 32'h0000_0000, exp_g: 1};

        srst      = 1'b1;
        s_req_vld = '0;
        s_wr_en   = '0;
        s_rd_en   = '0;
        s_addr    = '0;
        s_wr_data = '0;
        s_ack_rdy = '0;
        req_rdy   = 1'b0;
        ack_vld   = 1'b0;
        rd_data   = '0;
        tick();
        tick();
        #1;
        chk("rst_req_vld",   req_vld,   0);
        chk("rst_busy",      busy,      0);
        chk("rst_grant",     grant_idx, 0);
        chk("rst_s_req_rdy", s_req_rdy, 0);
        chk("rst_s_ack_vld", s_ack_vld, 0);
        chk("rst_ack_rdy",   ack_rdy,   0);
        srst = 1'b0;
        tick();

        // Table of complete single transactions
        for (int i = 0; i < 7; i++) begin
            for (int m = 0; m < N; m++) begin
                set_mst(m, vecs[i].wr, vecs[i].addr + 64'(m) * 64'h100, vecs[i].data + 32'(m));
            end
            s_req_vld = vecs[i].req;
            req_rdy   = 1'b1;
            s_ack_rdy = 2'b11;
            ack_vld   = 1'b0;
            #1;
            chk("idle_req_vld", req_vld, 0);
            tick();
            g  = vecs[i].exp_g;
            ea = vecs[i].addr + 64'(g) * 64'h100;
            chk("req_grant",   grant_idx, 64'(g));
            chk("req_vld",     req_vld,   1);
            chk("req_wr_en",   wr_en,     vecs[i].wr);
            chk("req_rd_en",   rd_en,     !vecs[i].wr);
            chk("req_addr",    addr,      ea);
            chk("req_wr_data", wr_data,   vecs[i].data + 32'(g));
            chk("req_s_rdy",   s_req_rdy, 64'(1) << g);
            tick();
            s_req_vld[g] = 1'b0;
            req_rdy      = 1'b0;
            ack_vld      = 1'b1;
            rd_data      = vecs[i].rdata;
            #1;
            chk("ack_s_vld",   s_ack_vld, 64'(1) << g);
            chk("ack_rd_data", s_rd_data, vecs[i].rdata);
            chk("ack_rdy",     ack_rdy,   1);
            chk("ack_busy",    busy,      1);
            chk("ack_req_vld", req_vld,   0);
            tick();
            ack_vld   = 1'b0;
            s_req_vld = '0;
            #1;
            chk("done_busy", busy, 0);
        end

        // Downstream stalls req_rdy for 5 cycles; an early ack must not leak
        set_mst(0, 1'b1, 64'hA000, 32'hCAFE_0000);
        set_mst(1, 1'b0, 64'hB000, 32'h0000_0000);
        s_req_vld = 2'b11;
        req_rdy   = 1'b0;
        s_ack_rdy = 2'b00;
        ack_vld   = 1'b1;
        rd_data   = 32'h5555_AAAA;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_grant",     grant_idx, 0);
            chk("stall_req_vld",   req_vld,   1);
            chk("stall_addr",      addr,      64'hA000);
            chk("stall_wr_data",   wr_data,   32'hCAFE_0000);
            chk("stall_s_req_rdy", s_req_rdy, 0);
            chk("stall_s_ack_vld", s_ack_vld, 0);
            chk("stall_ack_rdy",   ack_rdy,   0);
            tick();
        end
        req_rdy = 1'b1;
        #1;
        chk("stall_release_rdy", s_req_rdy, 2'b01);
        tick();
        s_req_vld[0] = 1'b0;
        req_rdy      = 1'b0;
        // Master 0 refuses the ack for 3 cycles
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ackhold_ack_rdy", ack_rdy,   0);
            chk("ackhold_s_vld",   s_ack_vld, 2'b01);
            chk("ackhold_busy",    busy,      1);
            tick();
        end
        s_ack_rdy[0] = 1'b1;
        #1;
        chk("ackhold_rdy4",  ack_rdy,   1);
        chk("ackhold_rdata", s_rd_data, 32'h5555_AAAA);
        tick();
        ack_vld   = 1'b0;
        s_ack_rdy = 2'b00;
        #1;
        chk("ackhold_idle", busy, 0);
        tick();
        chk("pending_grant", grant_idx, 1);
        chk("pending_addr",  addr,      64'hB000);
        chk("pending_rd_en", rd_en,     1);

        // Reset in ACK abandons the transaction and restores the pointer
        req_rdy = 1'b1;
        tick();
        s_req_vld = 2'b00;
        req_rdy   = 1'b0;
        ack_vld   = 1'b1;
        #1;
        chk("prerst_s_ack_vld", s_ack_vld, 2'b10);
        srst = 1'b1;
        tick();
        srst    = 1'b0;
        ack_vld = 1'b0;
        #1;
        chk("midrst_busy",      busy,      0);
        chk("midrst_req_vld",   req_vld,   0);
        chk("midrst_s_req_rdy", s_req_rdy, 0);
        chk("midrst_s_ack_vld", s_ack_vld, 0);
        chk("midrst_ack_rdy",   ack_rdy,   0);
        chk("midrst_grant",     grant_idx, 0);
        s_req_vld = 2'b11;
        tick();
        chk("postrst_grant", grant_idx, 0);
        chk("postrst_busy",  busy,      1);

`ifdef REG_ARB_TIMEOUT_EN
        // Slave never acks: synthetic ack after 16 cycles in ACK
        s_req_vld = 2'b00;
        srst      = 1'b1;
        tick();
        srst      = 1'b0;
        s_req_vld = 2'b01;
        req_rdy   = 1'b1;
        tick();
        tick();
        s_req_vld = 2'b00;
        req_rdy   = 1'b0;
        ack_vld   = 1'b0;
        s_ack_rdy = 2'b01;
        fire_at   = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (timeout_err) begin
                fire_at = k;
                chk("to_s_ack_vld", s_ack_vld, 2'b01);
                chk("to_rd_data",   s_rd_data, 32'hDEAD_BEEF);
                chk("to_ack_rdy",   ack_rdy,   0);
                break;
            end
            tick();
        end
        chk("to_cycle", 64'(fire_at), 64'd16);
        tick();
        chk("to_idle_busy", busy,        0);
        chk("to_pulse_end", timeout_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reg_native_arb

`default_nettype wire
